// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the shift-register blocks: FSM state encoding and
// the helper that sizes bit counters.
package piso_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } piso_state_e;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter: synchronous clear, enable, and a terminal-count flag
// at WIDTH-1. It saturates there instead of wrapping.
module piso_serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready word interface.
// state  | meaning
// IDLE   | no word held, outputs quiet, ready for a word
// SHIFT  | presenting one bit per cycle; ready again on the last bit
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy
);

    piso_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             head_d;
    logic [WIDTH-1:0] src;
    logic             serial_out_q;
    logic             serial_valid_q;
    logic             frame_start_q;
    logic             busy_q;
    logic             cnt_tc;
    logic             accept;

    assign in_ready = (state_q == S_IDLE) || cnt_tc;
    assign accept   = in_valid && in_ready;

    piso_serializer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr_i (accept),
        .en_i  (state_q == S_SHIFT),
        .tc_o  (cnt_tc)
    );

    // The shift register holds only the bits not yet presented; the bit on
    // serial_out lives in its own flop so the output is registered.
    always_comb begin
        src     = accept ? in_data : shreg_q;
        head_d  = (LSB_FIRST != 0) ? src[0] : src[WIDTH-1];
        shreg_d = (LSB_FIRST != 0) ? (src >> 1) : (src << 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            shreg_q        <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else if (accept) begin
            state_q        <= S_SHIFT;
            shreg_q        <= shreg_d;
            serial_out_q   <= head_d;
            serial_valid_q <= 1'b1;
            frame_start_q  <= 1'b1;
            busy_q         <= 1'b1;
        end else if (state_q == S_SHIFT) begin
            frame_start_q <= 1'b0;
            if (cnt_tc) begin
                state_q        <= S_IDLE;
                shreg_q        <= '0;
                serial_out_q   <= 1'b0;
                serial_valid_q <= 1'b0;
                busy_q         <= 1'b0;
            end else begin
                shreg_q      <= shreg_d;
                serial_out_q <= head_d;
            end
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_start  = frame_start_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (8-bit LSB-first, 8-bit MSB-first,
// 4-bit LSB-first) checked every cycle against a bit-queue reference model.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  vld_v;
    logic [31:0] din [3];
    logic [2:0]  rdy_v, so_v, sv_v, fs_v, bsy_v;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(rst_v[0]), .in_data(din[0][7:0]), .in_valid(vld_v[0]),
        .in_ready(rdy_v[0]), .serial_out(so_v[0]), .serial_valid(sv_v[0]),
        .frame_start(fs_v[0]), .busy(bsy_v[0]));

    piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(rst_v[1]), .in_data(din[1][7:0]), .in_valid(vld_v[1]),
        .in_ready(rdy_v[1]), .serial_out(so_v[1]), .serial_valid(sv_v[1]),
        .frame_start(fs_v[1]), .busy(bsy_v[1]));

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1)) u_w4 (
        .clk(clk), .reset(rst_v[2]), .in_data(din[2][3:0]), .in_valid(vld_v[2]),
        .in_ready(rdy_v[2]), .serial_out(so_v[2]), .serial_valid(sv_v[2]),
        .frame_start(fs_v[2]), .busy(bsy_v[2]));

    int checks = 0;
    int passes = 0;

    // Reference model: per instance, the queue of bits still to appear on
    // serial_out; element 0 is the bit visible in the current cycle.
    int dw [3] = '{8, 8, 4};
    int dl [3] = '{1, 0, 1};
    bit qb [3][64];
    bit qf [3][64];
    int qn [3];
    bit acc [3];

    typedef struct {
        int          dut;
        bit          rst;
        bit          vld;
        logic [31:0] data;
        bit          so;
        bit          sv;
        bit          fs;
        bit          rdy;
        bit          bsy;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input int d, input bit r, input bit v, input logic [31:0] w,
                                input bit so, input bit sv, input bit fs, input bit rdy, input bit bsy);
        vec_t t;
        t.dut = d; t.rst = r; t.vld = v; t.data = w;
        t.so = so; t.sv = sv; t.fs = fs; t.rdy = rdy; t.bsy = bsy;
        return t;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
    endtask

    task automatic model_push(input int d, input logic [31:0] w);
        for (int i = 0; i < dw[d]; i++) begin
            int idx;
            idx = (dl[d] != 0) ? i : dw[d] - 1 - i;
            qb[d][qn[d] + i] = w[idx];
            qf[d][qn[d] + i] = (i == 0);
        end
        qn[d] += dw[d];
    endtask

    task automatic model_pop(input int d);
        for (int i = 0; i < qn[d] - 1; i++) begin
            qb[d][i] = qb[d][i + 1];
            qf[d][i] = qf[d][i + 1];
        end
        qn[d]--;
    endtask

    // One clock: predict accepts, advance the model at the edge, then check
    // every instance 1 time unit after the edge.
    task automatic cycle();
        for (int d = 0; d < 3; d++)
            acc[d] = !rst_v[d] && vld_v[d] && (qn[d] <= 1);
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst_v[d]) qn[d] = 0;
            else begin
                if (qn[d] > 0) model_pop(d);
                if (acc[d]) model_push(d, din[d]);
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            bit e_sv;
            e_sv = (qn[d] > 0);
            chk("serial_valid", d, sv_v[d], e_sv);
            chk("serial_out", d, so_v[d], e_sv ? qb[d][0] : 1'b0);
            chk("frame_start", d, fs_v[d], e_sv ? qf[d][0] : 1'b0);
            chk("busy", d, bsy_v[d], e_sv);
            chk("in_ready", d, rdy_v[d], qn[d] <= 1);
        end
    endtask

    initial begin
        // 8'hA5 on both 8-bit instances; the pattern reads the same either way.
        for (int d = 0; d < 2; d++) begin
            tbl.push_back(mk(d, 1, 0, 32'h00, 0, 0, 0, 1, 0));
            tbl.push_back(mk(d, 0, 1, 32'hA5, 1, 1, 1, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 0, 1, 0, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 1, 1, 0, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 0, 1, 0, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 0, 1, 0, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 1, 1, 0, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 0, 1, 0, 0, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 1, 1, 0, 1, 1));
            tbl.push_back(mk(d, 0, 0, 32'h5A, 0, 0, 0, 1, 0));
        end

        rst_v = 3'b111;
        vld_v = 3'b000;
        for (int d = 0; d < 3; d++) begin din[d] = '0; qn[d] = 0; acc[d] = 0; end
        cycle();
        cycle();
        rst_v = 3'b000;

        foreach (tbl[i]) begin
            rst_v = 3'b000; vld_v = 3'b000;
            rst_v[tbl[i].dut] = tbl[i].rst;
            vld_v[tbl[i].dut] = tbl[i].vld;
            din[tbl[i].dut]   = tbl[i].data;
            cycle();
            chk("tbl serial_out", tbl[i].dut, so_v[tbl[i].dut], tbl[i].so);
            chk("tbl serial_valid", tbl[i].dut, sv_v[tbl[i].dut], tbl[i].sv);
            chk("tbl frame_start", tbl[i].dut, fs_v[tbl[i].dut], tbl[i].fs);
            chk("tbl in_ready", tbl[i].dut, rdy_v[tbl[i].dut], tbl[i].rdy);
            chk("tbl busy", tbl[i].dut, bsy_v[tbl[i].dut], tbl[i].bsy);
        end
        rst_v = 3'b000; vld_v = 3'b000;

        // Reset wins over a simultaneous accept.
        rst_v[0] = 1; vld_v[0] = 1; din[0] = 32'hFF;
        cycle();
        chk("rst_prio sv", 0, sv_v[0], 1'b0);
        rst_v[0] = 0; vld_v[0] = 0;
        cycle();
        chk("rst_prio no capture", 0, sv_v[0], 1'b0);

        // Back-to-back with in_valid held high: 3C then C3.
        begin
            int stage, nb;
            int fsat [$];
            logic [15:0] got;
            bit done;
            stage = 0; nb = 0; got = '0; done = 0;
            vld_v[0] = 1; din[0] = 32'h3C;
            for (int k = 0; k < 40 && !done; k++) begin
                cycle();
                if (acc[0]) begin
                    stage++;
                    if (stage == 1) din[0] = 32'hC3;
                    else vld_v[0] = 0;
                end
                if (sv_v[0]) begin
                    if (fs_v[0]) fsat.push_back(nb);
                    if (nb < 16) got[nb] = so_v[0];
                    nb++;
                end else if (nb > 0) done = 1;
            end
            vld_v[0] = 0;
            chk("b2b finished in bound", 0, done, 1'b1);
            chk("b2b valid run", 0, nb, 16);
            chk("b2b accepts", 0, stage, 2);
            chk("b2b frame count", 0, fsat.size(), 2);
            chk("b2b frame1 pos", 0, (fsat.size() > 0) ? fsat[0] : -1, 0);
            chk("b2b frame2 pos", 0, (fsat.size() > 1) ? fsat[1] : -1, 8);
            chk("b2b data", 0, got, 16'hC33C);
        end

        // Reset on bit 4 of 8'hFF, then 8'h01.
        begin
            logic [7:0] got;
            vld_v[0] = 1; din[0] = 32'hFF;
            cycle();
            vld_v[0] = 0; din[0] = 32'h00;
            for (int k = 0; k < 4; k++) cycle();
            chk("abort pre sv", 0, sv_v[0], 1'b1);
            rst_v[0] = 1;
            cycle();
            rst_v[0] = 0;
            chk("abort sv", 0, sv_v[0], 1'b0);
            chk("abort ready", 0, rdy_v[0], 1'b1);
            chk("abort busy", 0, bsy_v[0], 1'b0);
            vld_v[0] = 1; din[0] = 32'h01;
            cycle();
            vld_v[0] = 0;
            got = '0;
            for (int i = 0; i < 8; i++) begin
                got[i] = so_v[0] & sv_v[0];
                if (i < 7) cycle();
            end
            chk("after abort data", 0, got, 8'h01);
            cycle();
            chk("after abort idle", 0, sv_v[0], 1'b0);
        end

        // in_data churns while shifting; output must be the captured 8'h5A.
        begin
            logic [7:0] got;
            vld_v[1] = 1; din[1] = 32'h5A;
            cycle();
            vld_v[1] = 0;
            got = '0;
            for (int i = 0; i < 8; i++) begin
                got[7 - i] = so_v[1] & sv_v[1];
                din[1] = $urandom;
                if (i < 7) cycle();
            end
            chk("hold data msb", 1, got, 8'h5A);
            cycle();
        end

        // Random traffic on the 8-bit instances alongside a 1000-word loopback
        // through the 4-bit instance into a bench-side deserializer.
        begin
            int sent [$];
            logic [3:0] rx;
            int rxn, words_rx, gaps, cyc;
            bit started;
            rx = '0; rxn = 0; words_rx = 0; gaps = 0; cyc = 0; started = 0;
            vld_v[2] = 1; din[2] = $urandom_range(0, 15);
            while (words_rx < 1000 && cyc < 6000) begin
                for (int d = 0; d < 2; d++) begin
                    if (!(vld_v[d] && !acc[d] && !rst_v[d])) begin
                        vld_v[d] = ($urandom_range(0, 2) != 0);
                        din[d]   = $urandom;
                        rst_v[d] = ($urandom_range(0, 63) == 0);
                    end else begin
                        rst_v[d] = 0;
                    end
                end
                cycle();
                cyc++;
                if (acc[2]) begin
                    sent.push_back(din[2]);
                    din[2] = $urandom_range(0, 15);
                end
                if (sv_v[2]) begin
                    started = 1;
                    if (fs_v[2]) rxn = 0;
                    rx[rxn[1:0]] = so_v[2];
                    rxn++;
                    if (rxn == 4) begin
                        chk("loopback word", 2, rx, (sent.size() > 0) ? sent.pop_front() : -1);
                        words_rx++;
                        rxn = 0;
                    end
                end else if (started) gaps++;
            end
            chk("loopback words", 2, words_rx, 1000);
            chk("loopback gaps", 2, gaps, 0);
        end

        vld_v = 3'b000; rst_v = 3'b000;
        for (int k = 0; k < 10; k++) cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
